// File: rtl/mips_checkpoint_monitor.sv
// ---------------------------------------------------------------------------
// mips_checkpoint_monitor
//   Self-check sequencer for the MIPS single-cycle core. It owns the core
//   reset and counts cycles from reset release. It walks a programmable
//   table of timed checkpoints and compares one probe channel per entry
//   against an expected value. It reports pass/fail, the number of
//   mismatches and the first failing entry.
//
//   Optional feature macro: CHECK_STOP_ON_FAIL_EN
//     defined   : the first failure ends the run. fail_count is then 1.
//     undefined : every entry is checked, and every failure is counted.
//
//   Timeout rule: once cycle_count reaches all-ones, the entry currently at
//   the pointer is still compared (it is necessarily due). Every entry after
//   it is counted as a failure, and the run ends.
// ---------------------------------------------------------------------------
module mips_checkpoint_monitor #(
  parameter int DATA_W       = 32,
  parameter int NUM_PROBES   = 4,   // >= 2
  parameter int NUM_CHECKS   = 8,   // >= 2
  parameter int CYC_W        = 16,
  parameter int RESET_CYCLES = 2    // >= 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_CHECKS)-1:0]   cfg_idx,
  input  logic [CYC_W-1:0]                cfg_cycle,
  input  logic [$clog2(NUM_PROBES)-1:0]   cfg_probe,
  input  logic [DATA_W-1:0]               cfg_expected,
  input  logic [$clog2(NUM_CHECKS):0]     cfg_num,
  input  logic                            start,
  input  logic [NUM_PROBES*DATA_W-1:0]    probe_data,
  output logic                            core_reset,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [$clog2(NUM_CHECKS):0]     fail_count,
  output logic [$clog2(NUM_CHECKS)-1:0]   first_fail_idx,
  output logic [DATA_W-1:0]               first_fail_val,
  output logic [CYC_W-1:0]                cycle_count
);

  localparam int IDX_W = $clog2(NUM_CHECKS);
  localparam int PS_W  = $clog2(NUM_PROBES);
  localparam int FC_W  = $clog2(NUM_CHECKS) + 1;
  localparam int HC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [HC_W-1:0] HOLD_LAST   = HC_W'(RESET_CYCLES - 1);
  localparam logic [FC_W-1:0] NUM_CHECK_V = FC_W'(NUM_CHECKS);

  typedef enum logic [1:0] {
    S_IDLE,   // core held in reset, waiting for start
    S_HOLD,   // core reset asserted for RESET_CYCLES cycles
    S_RUN,    // core running, checkpoints being consumed
    S_DONE    // core frozen, results stable
  } state_t;

  // Checkpoint table
  logic [CYC_W-1:0]  r_tbl_cycle [NUM_CHECKS];
  logic [PS_W-1:0]   r_tbl_probe [NUM_CHECKS];
  logic [DATA_W-1:0] r_tbl_exp   [NUM_CHECKS];

  // Run state
  state_t            r_state;
  state_t            w_state_nxt;
  logic [HC_W-1:0]   r_hold_cnt;
  logic [FC_W-1:0]   r_num;       // entries active in this run (clamped)
  logic [FC_W-1:0]   r_ptr;       // next entry to check
  logic [CYC_W-1:0]  r_cycle;
  logic [FC_W-1:0]   r_fail_cnt;
  logic [IDX_W-1:0]  r_ff_idx;
  logic [DATA_W-1:0] r_ff_val;

  // Current-entry decode and compare
  logic [IDX_W-1:0]  w_ptr_idx;
  logic [CYC_W-1:0]  w_ent_cycle;
  logic [PS_W-1:0]   w_ent_probe;
  logic [DATA_W-1:0] w_ent_exp;
  logic [DATA_W-1:0] w_probe_val;
  logic              w_probe_ok;  // selected channel exists
  logic              w_due;
  logic              w_sat;
  logic              w_last;
  logic              w_mismatch;
  logic              w_timeout;   // later entries can no longer be reached
  logic [FC_W-1:0]   w_left;      // entries after the current one
  logic [FC_W-1:0]   w_fail_inc;
  logic              w_start_run;
  logic              w_busy;

  assign w_busy      = (r_state == S_HOLD) || (r_state == S_RUN);
  assign w_ptr_idx   = r_ptr[IDX_W-1:0];
  assign w_ent_cycle = r_tbl_cycle[w_ptr_idx];
  assign w_ent_probe = r_tbl_probe[w_ptr_idx];
  assign w_ent_exp   = r_tbl_exp[w_ptr_idx];

  // Table write port. The host cannot change entries while a run uses them.
  // NOTE: the table has no reset. Its contents survive reset by design, and
  // leaving a RAM unreset lets it map onto block/distributed memory.
  always_ff @(posedge clk) begin
    if (cfg_we && !w_busy) begin
      r_tbl_cycle[cfg_idx] <= cfg_cycle;
      r_tbl_probe[cfg_idx] <= cfg_probe;
      r_tbl_exp[cfg_idx]   <= cfg_expected;
    end
  end

  // Probe channel mux. A selector with no matching channel flags the entry bad.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value unassigned (which would infer a latch).
  always_comb begin
    w_probe_val = '0;
    w_probe_ok  = 1'b0;
    for (int k = 0; k < NUM_PROBES; k++) begin
      if (w_ent_probe == PS_W'(k)) begin
        w_probe_val = probe_data[k*DATA_W +: DATA_W];
        w_probe_ok  = 1'b1;
      end
    end
  end

  // Checkpoint evaluation for the entry at the pointer.
  always_comb begin
    w_due      = (r_state == S_RUN) && (r_cycle >= w_ent_cycle);
    w_sat      = &r_cycle;
    w_last     = ((r_ptr + FC_W'(1)) == r_num);
    w_left     = r_num - r_ptr - FC_W'(1);
    w_mismatch = w_due && (!w_probe_ok || (w_probe_val != w_ent_exp));
    w_timeout  = w_due && w_sat && !w_last;
`ifdef CHECK_STOP_ON_FAIL_EN
    w_fail_inc = (w_mismatch || w_timeout) ? FC_W'(1) : FC_W'(0);
`else
    w_fail_inc = (w_mismatch ? FC_W'(1) : FC_W'(0)) +
                 (w_timeout  ? w_left   : FC_W'(0));
`endif
  end

  // Sequencer next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_HOLD;
          w_start_run = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = (r_num == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_due && (w_last || w_sat)) begin
          w_state_nxt = S_DONE;
        end
`ifdef CHECK_STOP_ON_FAIL_EN
        else if (w_mismatch) begin
          w_state_nxt = S_DONE;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Run datapath: hold timer, pointer, cycle counter and failure record.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_num      <= '0;
      r_ptr      <= '0;
      r_cycle    <= '0;
      r_fail_cnt <= '0;
      r_ff_idx   <= '0;
      r_ff_val   <= '0;
    end else if (w_start_run) begin
      r_hold_cnt <= '0;
      r_num      <= (cfg_num > NUM_CHECK_V) ? NUM_CHECK_V : cfg_num;
      r_ptr      <= '0;
      r_cycle    <= '0;
      r_fail_cnt <= '0;
      r_ff_idx   <= '0;
      r_ff_val   <= '0;
    end else if (r_state == S_HOLD) begin
      r_hold_cnt <= r_hold_cnt + HC_W'(1);
    end else if (r_state == S_RUN) begin
      if (w_due) begin
        r_ptr <= r_ptr + FC_W'(1);
      end
      // The counter freezes on the edge that leaves RUN, so DONE shows the
      // cycle of the final check.
      if ((w_state_nxt == S_RUN) && !w_sat) begin
        r_cycle <= r_cycle + CYC_W'(1);
      end
      r_fail_cnt <= r_fail_cnt + w_fail_inc;
      if (r_fail_cnt == '0) begin
        if (w_mismatch) begin
          r_ff_idx <= w_ptr_idx;
          r_ff_val <= w_probe_val;
        end else if (w_timeout) begin
          r_ff_idx <= w_ptr_idx + IDX_W'(1);
          r_ff_val <= '0;
        end
      end
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    core_reset     = (r_state != S_RUN);
    busy           = w_busy;
    done           = (r_state == S_DONE);
    pass           = (r_state == S_DONE) && (r_fail_cnt == '0);
    fail_count     = r_fail_cnt;
    first_fail_idx = r_ff_idx;
    first_fail_val = r_ff_val;
    cycle_count    = r_cycle;
  end

endmodule

// File: tb/tb_mips_checkpoint_monitor.sv
// ---------------------------------------------------------------------------
// tb_mips_checkpoint_monitor
//   Directed bench for mips_checkpoint_monitor. A timeline model computes the
//   expected result of each run from the checkpoint rules. One compare process
//   checks the DUT outputs against that model on every cycle of a run.
//   Literal expectations after each run pin the model itself.
//   Probe 0 can be driven as a ramp that equals the run cycle number. Late
//   checks then show up as different probe values.
// ---------------------------------------------------------------------------
module tb_mips_checkpoint_monitor;

  localparam int DATA_W     = 32;
  localparam int NUM_PROBES = 4;
  localparam int NUM_CHECKS = 8;
  localparam int CYC_W      = 8;
  localparam int RST_C      = 2;
  localparam int CYC_MAX    = (1 << CYC_W) - 1;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         cfg_we = 1'b0;
  logic [2:0]                   cfg_idx = '0;
  logic [CYC_W-1:0]             cfg_cycle = '0;
  logic [1:0]                   cfg_probe = '0;
  logic [DATA_W-1:0]            cfg_expected = '0;
  logic [3:0]                   cfg_num = '0;
  logic                         start = 1'b0;
  logic [NUM_PROBES*DATA_W-1:0] probe_data;
  logic                         core_reset, busy, done, pass;
  logic [3:0]                   fail_count;
  logic [2:0]                   first_fail_idx;
  logic [DATA_W-1:0]            first_fail_val;
  logic [CYC_W-1:0]             cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int          tb_cyc = 0;      // free-running edge count
  int          m_base = 0;      // tb_cyc value in the first cycle after start
  bit          m_active = 1'b0; // compare process armed
  int          m_cyc [NUM_CHECKS];
  int          m_prb [NUM_CHECKS];
  logic [31:0] m_exp [NUM_CHECKS];
  int          m_num = 0;
  logic [31:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;
  bit          ramp = 1'b0;
  int          e_fails, e_ffi, e_last;
  logic [31:0] e_ffv;
  int          cp_n, cp_c;

  mips_checkpoint_monitor #(
    .DATA_W(DATA_W), .NUM_PROBES(NUM_PROBES), .NUM_CHECKS(NUM_CHECKS),
    .CYC_W(CYC_W), .RESET_CYCLES(RST_C)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_cycle(cfg_cycle), .cfg_probe(cfg_probe), .cfg_expected(cfg_expected),
    .cfg_num(cfg_num), .start(start), .probe_data(probe_data),
    .core_reset(core_reset), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_val(first_fail_val), .cycle_count(cycle_count)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // During run cycle c, the ramp probe carries the value c.
  assign probe_data = {p3, p2, p1, ramp ? 32'(tb_cyc - m_base - RST_C) : p0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] probe_at(input int k, input int c);
    case (k)
      0:       return ramp ? 32'(c) : p0;
      1:       return p1;
      2:       return p2;
      3:       return p3;
      default: return 32'd0;
    endcase
  endfunction

  // Walks the table as the checkpoint rules describe: each entry is checked
  // at the later of its own cycle and one past the previous check.
  task automatic model_run();
    int t;
    bit stop;
    logic [31:0] v;
    bit ok;
    t = 0;
    stop = 1'b0;
`ifdef CHECK_STOP_ON_FAIL_EN
    stop = 1'b1;
`endif
    e_fails = 0; e_ffi = 0; e_ffv = '0; e_last = -1;
    for (int j = 0; j < m_num; j++) begin
      if (m_cyc[j] > t) t = m_cyc[j];
      v  = probe_at(m_prb[j], t);
      ok = (m_prb[j] < NUM_PROBES) && (v == m_exp[j]);
      e_last = t;
      if (!ok) begin
        if (e_fails == 0) begin e_ffi = j; e_ffv = v; end
        e_fails++;
        if (stop) break;
      end
      if (t == CYC_MAX) begin
        if (j + 1 < m_num) begin
          if (e_fails == 0) begin e_ffi = j + 1; e_ffv = '0; end
          e_fails += stop ? 1 : (m_num - j - 1);
        end
        break;
      end
      t++;
    end
  endtask

  // Compare process: every cycle of an armed run, the outputs are checked
  // against the model timeline (HOLD, then RUN cycles, then DONE).
  always @(negedge clk) begin
    if (m_active) begin
      cp_n = tb_cyc - m_base;
      if (cp_n < RST_C) begin
        check("hold_core_reset", 64'(core_reset), 64'(1));
        check("hold_busy",       64'(busy),       64'(1));
        check("hold_done",       64'(done),       64'(0));
        check("hold_fail_count", 64'(fail_count), 64'(0));
      end else begin
        cp_c = cp_n - RST_C;
        if (cp_c <= e_last) begin
          check("run_core_reset",  64'(core_reset),  64'(0));
          check("run_busy",        64'(busy),        64'(1));
          check("run_done",        64'(done),        64'(0));
          check("run_cycle_count", 64'(cycle_count), 64'(cp_c));
        end else begin
          check("done_core_reset",  64'(core_reset),     64'(1));
          check("done_busy",        64'(busy),           64'(0));
          check("done_done",        64'(done),           64'(1));
          check("done_pass",        64'(pass),           64'(e_fails == 0));
          check("done_fail_count",  64'(fail_count),     64'(e_fails));
          check("done_ff_idx",      64'(first_fail_idx), 64'(e_ffi));
          check("done_ff_val",      64'(first_fail_val), 64'(e_ffv));
          check("done_cycle_count", 64'(cycle_count),    64'((e_last < 0) ? 0 : e_last));
        end
      end
    end
  end

  task automatic write_entry(input int idx, input int cyc, input int prb, input logic [31:0] exp);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_cycle = CYC_W'(cyc);
    cfg_probe = 2'(prb); cfg_expected = exp;
    @(negedge clk);
    cfg_we = 1'b0;
    m_cyc[idx] = cyc; m_prb[idx] = prb; m_exp[idx] = exp;
  endtask

  task automatic start_run(input int num);
    m_active = 1'b0;
    m_num = num;
    model_run();
    @(negedge clk);
    cfg_num = 4'(num);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_base = tb_cyc;
    m_active = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_done", 64'(done), 64'(1));
  endtask

  task automatic finish_run();
    repeat (2) @(negedge clk);
    m_active = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_core_reset",  64'(core_reset),     64'(1));
    check("rst_busy",        64'(busy),           64'(0));
    check("rst_done",        64'(done),           64'(0));
    check("rst_pass",        64'(pass),           64'(0));
    check("rst_fail_count",  64'(fail_count),     64'(0));
    check("rst_ff_idx",      64'(first_fail_idx), 64'(0));
    check("rst_ff_val",      64'(first_fail_val), 64'(0));
    check("rst_cycle_count", 64'(cycle_count),    64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_core_reset", 64'(core_reset), 64'(1));
    check("idle_busy",       64'(busy),       64'(0));

    // Three timed checkpoints, all matching
    write_entry(0, 3, 2, 32'd5);
    write_entry(1, 8, 3, 32'd2);
    write_entry(2, 12, 1, 32'd10);
    p1 = 32'd10; p2 = 32'd5; p3 = 32'd2;
    start_run(3);
    wait_done(400);
    check("t1_pass",        64'(pass),        64'(1));
    check("t1_fail_count",  64'(fail_count),  64'(0));
    check("t1_cycle_count", 64'(cycle_count), 64'(12));
    finish_run();

    // Restart from DONE. A start and a table write during the run are ignored.
    start_run(3);
    repeat (6) @(negedge clk);
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_cycle = 8'd3;
    cfg_probe = 2'd2; cfg_expected = 32'd99;
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    wait_done(400);
    check("t1b_pass", 64'(pass), 64'(1));
    finish_run();

    // Reset in the middle of a run that has already failed once
    p3 = 32'd7;
    start_run(3);
    repeat (RST_C + 10) @(negedge clk);
    m_active = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("t5_core_reset", 64'(core_reset), 64'(1));
    check("t5_busy",       64'(busy),       64'(0));
    check("t5_done",       64'(done),       64'(0));
    check("t5_fail_count", 64'(fail_count), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Entry 1 mismatch (probe3=7, expected 2). The table survived the reset.
    start_run(3);
    wait_done(400);
    check("t2_pass",       64'(pass),           64'(0));
    check("t2_fail_count", 64'(fail_count),     64'(1));
    check("t2_ff_idx",     64'(first_fail_idx), 64'(1));
    check("t2_ff_val",     64'(first_fail_val), 64'(7));
    finish_run();

    // Two entries due at cycle 4 are checked at cycles 4 and 5
    ramp = 1'b1;
    write_entry(0, 4, 0, 32'd4);
    write_entry(1, 4, 0, 32'd5);
    start_run(2);
    wait_done(400);
    check("t3_pass",        64'(pass),        64'(1));
    check("t3_cycle_count", 64'(cycle_count), 64'(5));
    finish_run();

    // Two mismatches
    write_entry(0, 4, 0, 32'd9);
    write_entry(1, 4, 0, 32'd9);
    start_run(2);
    wait_done(400);
`ifdef CHECK_STOP_ON_FAIL_EN
    check("t6_fail_count",  64'(fail_count),  64'(1));
    check("t6_cycle_count", 64'(cycle_count), 64'(4));
`else
    check("t6_fail_count",  64'(fail_count),  64'(2));
    check("t6_cycle_count", 64'(cycle_count), 64'(5));
`endif
    check("t6_ff_idx", 64'(first_fail_idx), 64'(0));
    check("t6_ff_val", 64'(first_fail_val), 64'(4));
    finish_run();

    // Empty table: hold only, then done and pass
    start_run(0);
    wait_done(100);
    check("t4_pass",        64'(pass),        64'(1));
    check("t4_fail_count",  64'(fail_count),  64'(0));
    check("t4_cycle_count", 64'(cycle_count), 64'(0));
    finish_run();

    // Counter saturation: the last entry cannot be reached
    ramp = 1'b0;
    p1 = 32'd10; p2 = 32'd5; p3 = 32'd2;
    write_entry(0, 250, 1, 32'd10);
    write_entry(1, 255, 2, 32'd5);
    write_entry(2, 255, 3, 32'd2);
    start_run(3);
    wait_done(600);
    check("t9_fail_count",  64'(fail_count),     64'(1));
    check("t9_ff_idx",      64'(first_fail_idx), 64'(2));
    check("t9_ff_val",      64'(first_fail_val), 64'(0));
    check("t9_cycle_count", 64'(cycle_count),    64'(255));
    check("t9_pass",        64'(pass),           64'(0));
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
